// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel window datapath: mode encodings and
// the width helper for the full-precision tap sum.
package pixel_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // Enough headroom that summing DEPTH full-scale words can never wrap.
  function automatic int sum_w(input int width, input int depth);
    return width + $clog2(depth);
  endfunction

endpackage

// File: rtl/tap_reg.sv
// One pixel word of the window: a plain enabled register with sync reset.
module tap_reg #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] DI,
  output logic [WIDTH-1:0] DOUT
);

  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge CLK) begin
    if (RESET)   dout_q <= '0;
    else if (CE) dout_q <= DI;
  end

  assign DOUT = dout_q;

endmodule

// File: rtl/pixel_window_reg.sv
// Sliding window of DEPTH pixel words with fill tracking and a registered
// tap sum feeding the sharpen/blur kernel stage.
module pixel_window_reg
  import pixel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              CE,
  input  logic [1:0]                        MODE,
  input  logic [WIDTH-1:0]                  DI,
  input  logic [$clog2(DEPTH)-1:0]          IDX,
  output logic [WIDTH*DEPTH-1:0]            TAPS,
  output logic [$clog2(DEPTH+1)-1:0]        COUNT,
  output logic                              FULL,
  output logic                              FILL_DONE,
  output logic [sum_w(WIDTH, DEPTH)-1:0]    SUM
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = sum_w(WIDTH, DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] taps;
  logic [DEPTH-1:0][WIDTH-1:0] tap_d;
  logic [DEPTH-1:0]            tap_en;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tap
    logic [WIDTH-1:0] shift_src;

    if (i == 0) begin : g_head
      assign shift_src = DI;
    end else begin : g_body
      assign shift_src = taps[i-1];
    end

    // Out-of-range IDX matches no tap, so WRITE silently does nothing.
    always_comb begin
      tap_en[i] = 1'b0;
      tap_d[i]  = shift_src;
      unique case (MODE)
        MODE_SHIFT: tap_en[i] = 1'b1;
        MODE_WRITE: begin
          tap_en[i] = (IDX == IW'(i));
          tap_d[i]  = DI;
        end
        MODE_CLEAR: begin
          tap_en[i] = 1'b1;
          tap_d[i]  = '0;
        end
        default: tap_en[i] = 1'b0;
      endcase
    end

    tap_reg #(.WIDTH(WIDTH)) u_tap (
      .CLK   (CLK),
      .RESET (RESET),
      .CE    (CE & tap_en[i]),
      .DI    (tap_d[i]),
      .DOUT  (taps[i])
    );
  end

  logic [CW-1:0] count_q, count_d;
  logic          fill_done_q, fill_done_d;

  always_comb begin
    count_d     = count_q;
    fill_done_d = 1'b0;
    if (CE) begin
      unique case (MODE)
        MODE_SHIFT: begin
          if (count_q != DEPTH_C) count_d = count_q + CW'(1);
          fill_done_d = (count_q == DEPTH_C - CW'(1));
        end
        MODE_CLEAR: count_d = '0;
        default:    count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q     <= '0;
      fill_done_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Sum runs every cycle off the registered taps, so it trails them by one.
  logic [SW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < DEPTH; i++) sum_d = sum_d + SW'(taps[i]);
  end

  always_ff @(posedge CLK) begin
    if (RESET) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign TAPS      = taps;
  assign COUNT     = count_q;
  assign FULL      = (count_q == DEPTH_C);
  assign FILL_DONE = fill_done_q;
  assign SUM       = sum_q;

endmodule

// File: tb/tb_pixel_window_reg.sv
// Directed vector bench for pixel_window_reg at WIDTH=8, DEPTH=3.
module tb_pixel_window_reg;
  import pixel_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CE = 1'b0;
  logic [1:0]  MODE = MODE_HOLD;
  logic [7:0]  DI = '0;
  logic [1:0]  IDX = '0;
  logic [23:0] TAPS;
  logic [1:0]  COUNT;
  logic        FULL;
  logic        FILL_DONE;
  logic [9:0]  SUM;

  pixel_window_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .MODE(MODE), .DI(DI), .IDX(IDX),
    .TAPS(TAPS), .COUNT(COUNT), .FULL(FULL), .FILL_DONE(FILL_DONE), .SUM(SUM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ce;
    logic [1:0]  mode;
    logic [7:0]  di;
    logic [1:0]  idx;
    logic [23:0] taps;
    logic [1:0]  cnt;
    logic        full;
    logic        fd;
    logic [9:0]  sum;
  } vec_t;

  vec_t tv[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic rst, logic ce, logic [1:0] mode, logic [7:0] di,
                              logic [1:0] idx, logic [23:0] taps, logic [1:0] cnt,
                              logic full, logic fd, logic [9:0] sum);
    vec_t v;
    v.rst = rst; v.ce = ce; v.mode = mode; v.di = di; v.idx = idx;
    v.taps = taps; v.cnt = cnt; v.full = full; v.fd = fd; v.sum = sum;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic ce, input logic [1:0] mode,
                      input logic [7:0] di, input logic [1:0] idx);
    RESET = rst; CE = ce; MODE = mode; DI = di; IDX = idx;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // reset with SHIFT/CE asserted must still clear everything
    tv.push_back(mk(1,1,MODE_SHIFT,8'hAA,0, 24'h000000,0,0,0,10'h000));
    tv.push_back(mk(1,1,MODE_SHIFT,8'hAA,0, 24'h000000,0,0,0,10'h000));
    // fill
    tv.push_back(mk(0,1,MODE_SHIFT,8'h10,0, 24'h000010,1,0,0,10'h000));
    tv.push_back(mk(0,1,MODE_SHIFT,8'h20,0, 24'h001020,2,0,0,10'h010));
    tv.push_back(mk(0,1,MODE_SHIFT,8'h30,0, 24'h102030,3,1,1,10'h030));
    tv.push_back(mk(0,1,MODE_HOLD, 8'h00,0, 24'h102030,3,1,0,10'h060));
    // shift while full
    tv.push_back(mk(0,1,MODE_SHIFT,8'h40,0, 24'h203040,3,1,0,10'h060));
    tv.push_back(mk(0,1,MODE_HOLD, 8'h00,0, 24'h203040,3,1,0,10'h090));
    // CE low freezes state in every mode
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,0,MODE_SHIFT,8'h55,1, 24'h203040,3,1,0,10'h090));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,0,MODE_WRITE,8'h55,1, 24'h203040,3,1,0,10'h090));
    for (int k = 0; k < 3; k++)
      tv.push_back(mk(0,0,MODE_CLEAR,8'h55,1, 24'h203040,3,1,0,10'h090));
    // indexed write, then out-of-range index
    tv.push_back(mk(0,1,MODE_WRITE,8'hFF,1, 24'h20FF40,3,1,0,10'h090));
    tv.push_back(mk(0,1,MODE_WRITE,8'h77,3, 24'h20FF40,3,1,0,10'h15F));
    tv.push_back(mk(0,1,MODE_HOLD, 8'h00,0, 24'h20FF40,3,1,0,10'h15F));
    // clear; sum follows a cycle later
    tv.push_back(mk(0,1,MODE_CLEAR,8'h00,0, 24'h000000,0,0,0,10'h15F));
    tv.push_back(mk(0,1,MODE_HOLD, 8'h00,0, 24'h000000,0,0,0,10'h000));
    // full-scale refill: no wrap in sum, FILL_DONE re-fires after clear
    tv.push_back(mk(0,1,MODE_SHIFT,8'hFF,0, 24'h0000FF,1,0,0,10'h000));
    tv.push_back(mk(0,1,MODE_SHIFT,8'hFF,0, 24'h00FFFF,2,0,0,10'h0FF));
    tv.push_back(mk(0,1,MODE_SHIFT,8'hFF,0, 24'hFFFFFF,3,1,1,10'h1FE));
    tv.push_back(mk(0,0,MODE_SHIFT,8'h00,0, 24'hFFFFFF,3,1,0,10'h2FD));
    // reset with CE low
    tv.push_back(mk(1,0,MODE_SHIFT,8'h11,0, 24'h000000,0,0,0,10'h000));
    tv.push_back(mk(0,1,MODE_HOLD, 8'h00,0, 24'h000000,0,0,0,10'h000));
    // write to first and last taps
    tv.push_back(mk(0,1,MODE_WRITE,8'h05,0, 24'h000005,0,0,0,10'h000));
    tv.push_back(mk(0,1,MODE_WRITE,8'h07,2, 24'h070005,0,0,0,10'h005));
    tv.push_back(mk(0,1,MODE_HOLD, 8'h00,0, 24'h070005,0,0,0,10'h00C));
    // shift discards oldest, then reset mid-fill
    tv.push_back(mk(0,1,MODE_SHIFT,8'h01,0, 24'h000501,1,0,0,10'h00C));
    tv.push_back(mk(1,1,MODE_SHIFT,8'h99,0, 24'h000000,0,0,0,10'h000));

    #2;
    foreach (tv[r]) begin
      step(tv[r].rst, tv[r].ce, tv[r].mode, tv[r].di, tv[r].idx);
      chk("taps",      r, 32'(TAPS),      32'(tv[r].taps));
      chk("count",     r, 32'(COUNT),     32'(tv[r].cnt));
      chk("full",      r, 32'(FULL),      32'(tv[r].full));
      chk("fill_done", r, 32'(FILL_DONE), 32'(tv[r].fd));
      chk("sum",       r, 32'(SUM),       32'(tv[r].sum));
    end

    // fill interrupted by a CE-low cycle: pulse only on the third real shift
    step(0, 1, MODE_SHIFT, 8'h01, 0);
    chk("seq_count", 100, 32'(COUNT), 32'd1);
    step(0, 0, MODE_SHIFT, 8'h09, 0);
    chk("seq_count", 101, 32'(COUNT), 32'd1);
    chk("seq_fd",    101, 32'(FILL_DONE), 32'd0);
    step(0, 1, MODE_SHIFT, 8'h02, 0);
    chk("seq_fd",    102, 32'(FILL_DONE), 32'd0);
    step(0, 1, MODE_SHIFT, 8'h03, 0);
    chk("seq_count", 103, 32'(COUNT), 32'd3);
    chk("seq_fd",    103, 32'(FILL_DONE), 32'd1);
    chk("seq_taps",  103, 32'(TAPS), 32'h010203);
    step(0, 1, MODE_SHIFT, 8'h04, 0);
    chk("seq_fd",    104, 32'(FILL_DONE), 32'd0);
    chk("seq_full",  104, 32'(FULL), 32'd1);
    chk("seq_sum",   104, 32'(SUM), 32'h006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
